div_iter_responder: RTL and testbench

- Multi-cycle iterative integer divider; the responder end of the EXE stage divider stream handshake (divisor/dividend in, {quotient,remainder} out).
- Drop-in for the signed and unsigned divider instances: one instance with SIGNED=1 (div.w/mod.w), one with SIGNED=0 (div.wu/mod.wu).
- Restoring radix-2 algorithm; one operation in flight; fixed latency.

---
 rtl/div_iter_responder_pkg.sv | 13 +
 rtl/div_iter_responder_div_restore_step.sv | 28 ++
 rtl/div_iter_responder.sv | 167 ++++++++++++++++
 tb/tb_div_iter_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_responder_pkg.sv
// Shared definitions for the iterative divider: default operand width and FSM encoding.
package div_iter_responder_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_iter_responder_div_restore_step.sv
// One restoring radix-2 step: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   dvs,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;

    // shift in the next dividend bit and decide the quotient bit from the trial sign
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs};
        if (!trial_s[WIDTH+1]) begin
            rem_next = trial_s[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter_responder.sv
// Iterative restoring divider behind two independent operand streams; fixed WIDTH+3 cycle latency,
// one operation in flight, one-cycle result strobe with held data.
module div_iter_responder
    import div_iter_responder_pkg::*;
#(
    parameter int WIDTH  = DIV_W,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tvalid
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    div_state_e         state_r, state_s;
    logic               dvs_full_r, dvs_full_s, dvd_full_r, dvd_full_s;
    logic [WIDTH-1:0]   dvs_buf_r, dvs_buf_s, dvd_buf_r, dvd_buf_s;
    logic [WIDTH:0]     rem_r, rem_s, dvs_mag_r, dvs_mag_s;
    logic [WIDTH-1:0]   quo_r, quo_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic               qneg_r, qneg_s, rneg_r, rneg_s;
    logic [2*WIDTH-1:0] dout_r, dout_s;
    logic               vld_r, vld_s;

    logic               dvs_xfer_s, dvd_xfer_s, start_s;
    logic               dvs_neg_s, dvd_neg_s;
    logic [WIDTH-1:0]   dvs_abs_s, dvd_abs_s;
    logic [WIDTH:0]     rem_step_s;
    logic [WIDTH-1:0]   quo_step_s;
    logic [WIDTH-1:0]   q_fix_s, r_fix_s;

    assign s_axis_divisor_tready  = (state_r == ST_IDLE) && !dvs_full_r;
    assign s_axis_dividend_tready = (state_r == ST_IDLE) && !dvd_full_r;
    assign m_axis_dout_tdata      = dout_r;
    assign m_axis_dout_tvalid     = vld_r;

    assign dvs_xfer_s = s_axis_divisor_tvalid && s_axis_divisor_tready;
    assign dvd_xfer_s = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign start_s    = (state_r == ST_IDLE) && (dvs_full_r || dvs_xfer_s) && (dvd_full_r || dvd_xfer_s);

    // A W-bit unsigned magnitude already holds |-2^(W-1)| exactly; the extra bit is added for the trial subtract.
    assign dvs_neg_s = SIGNED && dvs_buf_r[WIDTH-1];
    assign dvd_neg_s = SIGNED && dvd_buf_r[WIDTH-1];
    assign dvs_abs_s = dvs_neg_s ? -dvs_buf_r : dvs_buf_r;
    assign dvd_abs_s = dvd_neg_s ? -dvd_buf_r : dvd_buf_r;
    assign q_fix_s   = qneg_r ? -quo_r : quo_r;
    assign r_fix_s   = rneg_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .dvs      (dvs_mag_r),
        .rem_next (rem_step_s),
        .quo_next (quo_step_s)
    );

    // next-state and datapath update for the operand buffers and the divide sequence
    always_comb begin
        state_s    = state_r;
        dvs_full_s = dvs_full_r;
        dvd_full_s = dvd_full_r;
        dvs_buf_s  = dvs_buf_r;
        dvd_buf_s  = dvd_buf_r;
        rem_s      = rem_r;
        quo_s      = quo_r;
        dvs_mag_s  = dvs_mag_r;
        cnt_s      = cnt_r;
        qneg_s     = qneg_r;
        rneg_s     = rneg_r;
        dout_s     = dout_r;
        vld_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dvs_xfer_s) begin
                    dvs_buf_s = s_axis_divisor_tdata;
                end else begin
                    dvs_buf_s = dvs_buf_r;
                end
                if (dvd_xfer_s) begin
                    dvd_buf_s = s_axis_dividend_tdata;
                end else begin
                    dvd_buf_s = dvd_buf_r;
                end
                if (start_s) begin
                    dvs_full_s = 1'b0;
                    dvd_full_s = 1'b0;
                    state_s    = ST_PREP;
                end else begin
                    dvs_full_s = dvs_full_r || dvs_xfer_s;
                    dvd_full_s = dvd_full_r || dvd_xfer_s;
                end
            end
            ST_PREP: begin
                quo_s     = dvd_abs_s;
                dvs_mag_s = {1'b0, dvs_abs_s};
                qneg_s    = dvd_neg_s ^ dvs_neg_s;
                rneg_s    = dvd_neg_s;
                rem_s     = {(WIDTH+1){1'b0}};
                cnt_s     = CNT_INIT;
                state_s   = ST_ITER;
            end
            ST_ITER: begin
                rem_s = rem_step_s;
                quo_s = quo_step_s;
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = ST_FIX;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_FIX: begin
                dout_s  = {q_fix_s, r_fix_s};
                vld_s   = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            dvs_full_r <= 1'b0;
            dvd_full_r <= 1'b0;
            dvs_buf_r  <= {WIDTH{1'b0}};
            dvd_buf_r  <= {WIDTH{1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            dvs_mag_r  <= {(WIDTH+1){1'b0}};
            cnt_r      <= {CW{1'b0}};
            qneg_r     <= 1'b0;
            rneg_r     <= 1'b0;
            dout_r     <= {(2*WIDTH){1'b0}};
            vld_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            dvs_full_r <= dvs_full_s;
            dvd_full_r <= dvd_full_s;
            dvs_buf_r  <= dvs_buf_s;
            dvd_buf_r  <= dvd_buf_s;
            rem_r      <= rem_s;
            quo_r      <= quo_s;
            dvs_mag_r  <= dvs_mag_s;
            cnt_r      <= cnt_s;
            qneg_r     <= qneg_s;
            rneg_r     <= rneg_s;
            dout_r     <= dout_s;
            vld_r      <= vld_s;
        end
    end

endmodule

// File: tb/tb_div_iter_responder.sv
// Scoreboard bench: a signed and an unsigned divider share one operand stream; each result is
// compared against plain-arithmetic division, including its arrival cycle.
module tb_div_iter_responder;

    localparam int LAT = 35;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] dvs_data = 32'd0, dvd_data = 32'd0;
    logic        dvs_valid = 1'b0, dvd_valid = 1'b0;
    logic        s_dvs_rdy, s_dvd_rdy, s_vld, u_dvs_rdy, u_dvd_rdy, u_vld;
    logic [63:0] s_out, u_out;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_s[$];
    exp_t exp_u[$];

    div_iter_responder #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clk(clk), .resetn(resetn),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(s_dvs_rdy),
        .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(s_dvd_rdy),
        .m_axis_dout_tdata(s_out), .m_axis_dout_tvalid(s_vld)
    );

    div_iter_responder #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clk(clk), .resetn(resetn),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(u_dvs_rdy),
        .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(u_dvd_rdy),
        .m_axis_dout_tdata(u_out), .m_axis_dout_tvalid(u_vld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference: truncating division, remainder follows the dividend, divide-by-zero as the restoring loop leaves it.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = (sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input int t);
        exp_t e;
        e.cyc  = t + LAT;
        e.data = model(1'b1, a, b);
        exp_s.push_back(e);
        e.data = model(1'b0, a, b);
        exp_u.push_back(e);
    endtask

    // Offers dividend a after da cycles and divisor b after db cycles; t is the start cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int da, input int db,
                         input bit expect_res, output int t);
        bit a_done, b_done, acc_a, acc_b;
        a_done = 1'b0;
        b_done = 1'b0;
        t = -1;
        for (int k = 0; k < 300 && t < 0; k++) begin
            dvd_valid = !a_done && (k >= da);
            dvd_data  = dvd_valid ? a : $urandom();
            dvs_valid = !b_done && (k >= db);
            dvs_data  = dvs_valid ? b : $urandom();
            @(negedge clk);
            acc_a = dvd_valid && s_dvd_rdy;
            acc_b = dvs_valid && s_dvs_rdy;
            @(posedge clk);
            #1;
            a_done = a_done || acc_a;
            b_done = b_done || acc_b;
            if (a_done && b_done) t = cyc - 1;
        end
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        if (t < 0) fail_now("issue_timeout");
        else if (expect_res) push_exp(a, b, t);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'd0;
            1: pick = 32'h8000_0000;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'($urandom_range(0, 20));
            4: pick = -32'($urandom_range(1, 20));
            default: pick = $urandom();
        endcase
    endfunction

    // Monitor: pops the scoreboard on every strobe and checks the following cycle for drop and hold.
    initial begin
        exp_t e;
        logic [63:0] last_s, last_u;
        bit s_after, u_after;
        last_s = 64'd0; last_u = 64'd0; s_after = 1'b0; u_after = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                last_s = 64'd0; last_u = 64'd0; s_after = 1'b0; u_after = 1'b0;
            end else begin
                if (s_vld) begin
                    if (exp_s.size() == 0) fail_now("s_unexpected_valid");
                    else begin
                        e = exp_s.pop_front();
                        chk("s_data", s_out, e.data);
                        chk("s_cycle", 64'(cyc), 64'(e.cyc));
                        last_s = e.data;
                        s_after = 1'b1;
                    end
                end else if (s_after) begin
                    chk("s_hold", s_out, last_s);
                    s_after = 1'b0;
                end
                if (u_vld) begin
                    if (exp_u.size() == 0) fail_now("u_unexpected_valid");
                    else begin
                        e = exp_u.pop_front();
                        chk("u_data", u_out, e.data);
                        chk("u_cycle", 64'(cyc), 64'(e.cyc));
                        last_u = e.data;
                        u_after = 1'b1;
                    end
                end else if (u_after) begin
                    chk("u_hold", u_out, last_u);
                    u_after = 1'b0;
                end
            end
        end
    end

    initial begin
        int t, t2;
        logic [31:0] a, b;
        logic [31:0] dir_a[6] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        logic [31:0] dir_b[6] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0};

        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_ready", 64'({s_dvs_rdy, s_dvd_rdy, u_dvs_rdy, u_dvd_rdy}), 64'hF);
        chk("reset_valid", 64'({s_vld, u_vld}), 64'h0);
        chk("reset_s_data", s_out, 64'd0);
        chk("reset_u_data", u_out, 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            issue(dir_a[i], dir_b[i], 0, 0, 1'b1, t);
            repeat (40) @(posedge clk);
            #1;
        end

        // split arrival: divisor first, dividend four cycles later, then junk offered while busy
        dvs_data = 32'd100; dvs_valid = 1'b1;
        @(negedge clk);
        chk("split_dvs_ready", 64'({s_dvs_rdy, u_dvs_rdy}), 64'h3);
        @(posedge clk);
        #1;
        dvs_valid = 1'b0; dvs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("split_ready_after", 64'({s_dvs_rdy, s_dvd_rdy, u_dvs_rdy, u_dvd_rdy}), 64'h5);
        repeat (3) @(posedge clk);
        #1;
        dvd_data = 32'hFFFF_FF9C; dvd_valid = 1'b1;
        @(negedge clk);
        chk("split_dvd_ready", 64'({s_dvd_rdy, u_dvd_rdy}), 64'h3);
        t = cyc;
        push_exp(32'hFFFF_FF9C, 32'd100, t);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            dvd_valid = 1'b1; dvs_valid = 1'b1; dvd_data = $urandom(); dvs_data = $urandom();
            @(negedge clk);
            chk("busy_ready", 64'({s_dvs_rdy, s_dvd_rdy, u_dvs_rdy, u_dvd_rdy}), 64'h0);
            @(posedge clk);
            #1;
        end
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // back-to-back: second pair offered from the cycle after the first start
        issue(32'd1000, 32'd7, 0, 0, 1'b1, t);
        issue(32'hFFFF_F000, 32'd3, 0, 0, 1'b1, t2);
        chk("b2b_accept_cycle", 64'(t2), 64'(t + LAT));
        repeat (40) @(posedge clk);
        #1;

        // reset in the middle of an operation
        issue(32'd12345, 32'd6, 0, 0, 1'b0, t);
        while (cyc < t + 20) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("midreset_ready", 64'({s_dvs_rdy, s_dvd_rdy, u_dvs_rdy, u_dvd_rdy}), 64'hF);
        chk("midreset_s_data", s_out, 64'd0);
        chk("midreset_u_data", u_out, 64'd0);
        repeat (45) @(posedge clk);
        #1;
        issue(32'd12345, 32'd6, 0, 0, 1'b1, t);

        for (int i = 0; i < 30; i++) begin
            a = pick();
            b = pick();
            issue(a, b, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, t);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        for (int k = 0; k < 200 && (exp_s.size() != 0 || exp_u.size() != 0); k++) @(posedge clk);
        @(negedge clk);
        chk("drain_pending", 64'(exp_s.size() + exp_u.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
